// File: rtl/dht11_ctrl.sv
// dht11_ctrl: single-wire DHT11 read sequencer. One start request produces
// the host start pulse, the sensor handshake, a 40-bit capture and a checksum
// check, all timed by an external 10 us tick strobe.
module dht11_ctrl #(
  parameter int unsigned START_TICKS   = 1800,
  parameter int unsigned WAIT_TICKS    = 3,
  parameter int unsigned BIT_THRESH    = 4,
  parameter int unsigned TIMEOUT_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tem_int,
  output logic [7:0] tem_dec
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP_L,
    RESP_H,
    BIT_L,
    BIT_H,
    CHECK
  } state_t;

  localparam logic [10:0] START_END = 11'(START_TICKS - 1);
  localparam logic [10:0] WAIT_END  = 11'(WAIT_TICKS - 1);
  localparam logic [10:0] THRESH    = 11'(BIT_THRESH);
  localparam logic [10:0] TMO       = 11'(TIMEOUT_TICKS);

  state_t      state;
  state_t      next;

  logic        sync1;
  logic        sync2;
  logic        line_q;
  logic        rise;
  logic        fall;

  logic [10:0] tcnt;
  logic [5:0]  bit_cnt;
  logic [39:0] data;
  logic        seen_low;

  logic        accept;
  logic        shift_en;
  logic        tmo_hit;
  logic        finish;
  logic        bit_val;
  logic [7:0]  sum;
  logic        sum_ok;

  // Line edges are taken from the synchronized level and its one-cycle-old copy.
  assign rise    = sync2 & ~line_q;
  assign fall    = ~sync2 & line_q;
  assign bit_val = (tcnt >= THRESH);
  assign sum     = data[39:32] + data[31:24] + data[23:16] + data[15:8];
  assign sum_ok  = (sum == data[7:0]);

  // Two-flop synchronizer for the asynchronous pad, plus a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= dht_in;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state decode; an observed edge takes priority over a same-cycle tick.
  always_comb begin
    next     = state;
    accept   = 1'b0;
    shift_en = 1'b0;
    tmo_hit  = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next   = START;
          accept = 1'b1;
        end
      end
      START: begin
        if (tick && (tcnt == START_END)) begin
          next = WAIT;
        end
      end
      WAIT: begin
        if (tick && (tcnt == WAIT_END)) begin
          next = RESP_L;
        end
      end
      RESP_L: begin
        if (tcnt >= TMO) begin
          tmo_hit = 1'b1;
          next    = IDLE;
        end else if (seen_low && rise) begin
          next = RESP_H;
        end
      end
      RESP_H: begin
        if (tcnt >= TMO) begin
          tmo_hit = 1'b1;
          next    = IDLE;
        end else if (fall) begin
          next = BIT_L;
        end
      end
      BIT_L: begin
        if (tcnt >= TMO) begin
          tmo_hit = 1'b1;
          next    = IDLE;
        end else if (rise) begin
          next = BIT_H;
        end
      end
      BIT_H: begin
        if (tcnt >= TMO) begin
          tmo_hit = 1'b1;
          next    = IDLE;
        end else if (fall) begin
          shift_en = 1'b1;
          next     = (bit_cnt == 6'd39) ? CHECK : BIT_L;
        end
      end
      CHECK: begin
        next = IDLE;
      end
      default: begin
        next = IDLE;
      end
    endcase
    finish = tmo_hit || (state == CHECK);
  end

  // Tick counter: cleared on every state change and held at zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if ((next != state) || (state == IDLE)) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= tcnt + 11'd1;
    end
  end

  // RESP_L must see the line low before its rising edge counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_low <= 1'b0;
    end else begin
      seen_low <= (state == RESP_L) && (seen_low || !sync2);
    end
  end

  // Bit capture: MSB first into the shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      data    <= {data[38:0], bit_val};
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Registered outputs; busy stays high through the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dht_oe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      dht_oe <= (next == START);
      busy   <= (next != IDLE) || finish;
      done   <= finish;
    end
  end

  // Result registers: bytes update only on a good checksum; error held until accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      error   <= 1'b0;
      hum_int <= '0;
      hum_dec <= '0;
      tem_int <= '0;
      tem_dec <= '0;
    end else if (accept) begin
      error <= 1'b0;
    end else if (state == CHECK) begin
      error <= !sum_ok;
      if (sum_ok) begin
        hum_int <= data[39:32];
        hum_dec <= data[31:24];
        tem_int <= data[23:16];
        tem_dec <= data[15:8];
      end
    end else if (tmo_hit) begin
      error <= 1'b1;
    end
  end

endmodule

// File: doc/dht11_ctrl.md
# dht11_ctrl

Single-wire DHT11 transaction controller. It sequences one complete sensor read per `start` request: host start pulse, sensor response handshake, 40-bit data capture and checksum check. It is timed entirely by the 10 µs `tick` strobe from the existing DHT tick generator, and sits between that generator, the bidirectional sensor pad and the display/UART logic that consumes humidity and temperature.

## Interface
- `START_TICKS`, default 1800: host low pulse length in ticks (18 ms).
- `WAIT_TICKS`, default 3: line-release time before sensing the response (30 µs).
- `BIT_THRESH`, default 4: high-phase tick count at or above which a bit is 1.
- `TIMEOUT_TICKS`, default 20: maximum ticks in any sensor-driven phase (200 µs).

- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: 10 µs single-cycle strobe from the tick generator.
- `start` in 1: request a read. Sampled only in IDLE.
- `dht_in` in 1: raw pad input, asynchronous.
- `dht_oe` out 1: 1 means the pad drives 0; 0 means released (pulled up).
- `busy` out 1: high from the cycle after accept until return to IDLE.
- `done` out 1: one-cycle pulse when a transaction ends, pass or fail.
- `error` out 1: registered with `done`; 1 means timeout or checksum failure. Held until the next accept.
- `hum_int`, `hum_dec`, `tem_int`, `tem_dec` out 8 each: last good reading.

## Operation
- `dht_in` passes through a 2-flop synchronizer, then a registered copy for edge detection. All line decisions use the synchronized value, which adds 2 cycles of input latency.
- Tick counter `tcnt` (11 bits) increments on `tick`. It clears on every state change. `bit_cnt` is 6 bits. Shift register `data` is 40 bits and shifts left, MSB first.
- States and transitions:
  - IDLE: `dht_oe`=0. On `start`=1, go to START and clear `error`.
  - START: `dht_oe`=1. When `tcnt`==START_TICKS-1 on a tick, go to WAIT.
  - WAIT: `dht_oe`=0. When `tcnt`==WAIT_TICKS-1 on a tick, go to RESP_L.
  - RESP_L: wait for line low, then for the rising edge, then go to RESP_H.
  - RESP_H: on the falling edge, go to BIT_L.
  - BIT_L: on the rising edge, clear `tcnt` and go to BIT_H.
  - BIT_H: on the falling edge, shift in (`tcnt`>=BIT_THRESH) and increment `bit_cnt`. If `bit_cnt` reaches 40, go to CHECK; otherwise go to BIT_L.
  - CHECK (1 cycle): compute sum = `data[39:32]`+`data[31:24]`+`data[23:16]`+`data[15:8]`, truncated to 8 bits, and compare it with `data[7:0]`.
    - Match: load the four output bytes and set `error`=0.
    - Mismatch: set `error`=1 and leave the outputs unchanged.
    - In both cases, pulse `done` and go to IDLE.
- Timeout: in RESP_L, RESP_H, BIT_L or BIT_H, if `tcnt` reaches TIMEOUT_TICKS, set `error`=1, pulse `done`, go to IDLE, release the line and leave the outputs unchanged.
- `start` outside IDLE is ignored, not queued.
- `reset` at any point: next cycle is IDLE with `dht_oe`=0, all counters cleared and every output at its reset value.

## Timing
- Reset values: `dht_oe`=0, `busy`=0, `done`=0, `error`=0, all data bytes 0x00, `data`=0.
- Accept: `start` high in IDLE at edge N gives `busy`=1 and `dht_oe`=1 after edge N.
- START length is START_TICKS ticks, ±1 tick phase uncertainty against the free-running generator.
- CHECK is exactly one cycle after the 40th falling edge is seen. The data bytes, `error` and `done` all update on the same edge.
- `busy` falls on the edge after `done`. A new `start` is accepted on that edge or later.
- Simultaneous edge and tick in one cycle: the edge wins. The state changes and `tcnt` clears, ignoring that tick.
- A high phase of exactly BIT_THRESH-1 ticks decodes as 0. BIT_THRESH ticks decodes as 1.

## Test plan
- Good frame, bytes 0x37 0x00 0x19 0x00 0x50 (0-bit high 27 µs, 1-bit high 70 µs): one `done` pulse, `error`=0, `hum_int`=0x37, `tem_int`=0x19.
- Same frame with checksum byte 0x51: `done` pulse, `error`=1, outputs keep their prior values (0x00 after reset).
- No sensor response (line held high after WAIT): `done` with `error`=1 exactly TIMEOUT_TICKS ticks into RESP_L, `dht_oe`=0, `busy` drops next cycle.
- `start` pulsed every cycle during a transaction: exactly one transaction and one `done`.
- `reset` asserted mid-START (500 ticks in): `dht_oe`=0 and `busy`=0 on the next edge. A following `start` gives a full 1800-tick low pulse.
- Bit boundary: high phases of 3 and 4 ticks decode as 0 and 1 respectively.
